alu_seq: RTL and testbench

Parametrised sequential ALU for the TP1 datapath, replacing the fixed 8-bit single-function logic units. Operand A, operand B and a MIPS-style function code are loaded one after another from a shared switch bus by three load strobes, in a fixed order enforced by a state machine. The block computes one of eight operations, registers the result and flags, and signals completion with a one-cycle `valid` pulse.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 79 +++++++
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state encoding shared by alu_seq and alu_core.
package alu_pkg;

    // MIPS-style function codes (6-bit encoding)
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    // Load sequence: A, then B, then opcode, then one execute cycle
    typedef enum logic [1:0] {
        ST_WAIT_A  = 2'd0,
        ST_WAIT_B  = 2'd1,
        ST_WAIT_OP = 2'd2,
        ST_EXEC    = 2'd3
    } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath (8 ops, result + flags + undefined-op error).
// Flag logic is present only when ALU_FLAGS_EN is defined; otherwise flags read 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 6
)(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [OPW-1:0]   i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_err
);
    localparam int M = WIDTH - 1;
    // Shift amounts at or beyond this saturate (SRL -> 0, SRA -> sign fill)
    localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_big;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;

    // Extra top bit gives add carry-out and, for subtraction, the borrow (A < B)
    assign w_add = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = {1'b0, i_a} - {1'b0, i_b};
    assign w_big = (i_b >= SH_LIM);

    // Operation select; undefined codes leave result 0 and raise err
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (i_op)
            OPW'(OP_ADD): begin
                w_res = w_add[M:0];
                w_c   = w_add[WIDTH];
                w_v   = (i_a[M] == i_b[M]) && (w_add[M] != i_a[M]);
            end
            OPW'(OP_SUB): begin
                w_res = w_sub[M:0];
                w_c   = w_sub[WIDTH];
                w_v   = (i_a[M] != i_b[M]) && (w_sub[M] != i_a[M]);
            end
            OPW'(OP_AND): w_res = i_a & i_b;
            OPW'(OP_OR):  w_res = i_a | i_b;
            OPW'(OP_XOR): w_res = i_a ^ i_b;
            OPW'(OP_NOR): w_res = ~(i_a | i_b);
            OPW'(OP_SRL): w_res = w_big ? '0 : (i_a >> i_b);
            OPW'(OP_SRA): w_res = w_big ? {WIDTH{i_a[M]}}
                                        : WIDTH'($signed(i_a) >>> i_b);
            default:      w_err = 1'b1;
        endcase
    end

    assign o_result = w_res;
    assign o_err    = w_err;

`ifdef ALU_FLAGS_EN
    // Zero is forced low on an undefined opcode even though result is 0
    assign o_zero     = ~w_err & (w_res == '0);
    assign o_carry    = w_c;
    assign o_overflow = w_v;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{w_c, w_v};
    assign o_zero     = 1'b0;
    assign o_carry    = 1'b0;
    assign o_overflow = 1'b0;
`endif

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. A, B and opcode are loaded in order from a shared
// bus by edge-detected strobes; the result registers one cycle after the
// opcode load and valid pulses for one cycle.
// Optional macro ALU_FLAGS_EN: when undefined, zero/carry/overflow are tied 0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 6
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err,
    output logic             valid,
    output logic             busy
);
    state_t           r_state;
    state_t           w_next;
    logic             r_prev_a;
    logic             r_prev_b;
    logic             r_prev_op;
    logic             w_edge_a;
    logic             w_edge_b;
    logic             w_edge_op;
    logic             w_take_a;
    logic             w_take_b;
    logic             w_take_op;
    logic             w_exec;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_carry;
    logic             w_overflow;
    logic             w_err;

    // Strobe history; reset to 1 so a strobe held through reset is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_a  <= 1'b1;
            r_prev_b  <= 1'b1;
            r_prev_op <= 1'b1;
        end else begin
            r_prev_a  <= ld_a;
            r_prev_b  <= ld_b;
            r_prev_op <= ld_op;
        end
    end

    assign w_edge_a  = ld_a  & ~r_prev_a;
    assign w_edge_b  = ld_b  & ~r_prev_b;
    assign w_edge_op = ld_op & ~r_prev_op;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_WAIT_A;
        else        r_state <= w_next;
    end

    // FSM next state: only the strobe matching the current state advances it
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT_A:  if (w_edge_a)  w_next = ST_WAIT_B;
            ST_WAIT_B:  if (w_edge_b)  w_next = ST_WAIT_OP;
            ST_WAIT_OP: if (w_edge_op) w_next = ST_EXEC;
            ST_EXEC:    w_next = ST_WAIT_A;
            default:    w_next = ST_WAIT_A;
        endcase
    end

    // FSM outputs: per-state load enables, execute strobe and busy
    always_comb begin
        w_take_a  = (r_state == ST_WAIT_A)  & w_edge_a;
        w_take_b  = (r_state == ST_WAIT_B)  & w_edge_b;
        w_take_op = (r_state == ST_WAIT_OP) & w_edge_op;
        w_exec    = (r_state == ST_EXEC);
        busy      = (r_state != ST_WAIT_A);
    end

    // Operand/opcode capture; reset clears any partially loaded sequence
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
        end else begin
            if (w_take_a)  r_a  <= sw;
            if (w_take_b)  r_b  <= sw;
            if (w_take_op) r_op <= sw[OPW-1:0];
        end
    end

    alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_core (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_op       (r_op),
        .o_result   (w_result),
        .o_zero     (w_zero),
        .o_carry    (w_carry),
        .o_overflow (w_overflow),
        .o_err      (w_err)
    );

    // Result register and completion pulse, updated only in EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            err    <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= w_exec;
            if (w_exec) begin
                result <= w_result;
                err    <= w_err;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    // Flag registers, same update rule as the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (w_exec) begin
            zero     <= w_zero;
            carry    <= w_carry;
            overflow <= w_overflow;
        end
    end
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{w_zero, w_carry, w_overflow};
    assign zero     = 1'b0;
    assign carry    = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=8). Stimulus pushes the
// expected response into a queue; a monitor pops and checks on every valid.
// Flag expectations follow ALU_FLAGS_EN (flags read 0 when undefined).
module tb_alu_seq;
    import alu_pkg::*;

`ifdef ALU_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct {
        logic [7:0] res;
        bit         z;
        bit         c;
        bit         v;
        bit         e;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = '0;
    logic       ld_a = 1'b0;
    logic       ld_b = 1'b0;
    logic       ld_op = 1'b0;
    logic [7:0] result;
    logic       zero, carry, overflow, err, valid, busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;
    exp_t q[$];

    alu_seq #(.WIDTH(8), .OPW(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .ld_op    (ld_op),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow),
        .err      (err),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t x;
        if (valid) begin
            chk("valid_not_consecutive", int'(prev_valid), 0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid=1 at cycle %0d want none", cyc);
            end else begin
                x = q.pop_front();
                chk("latency_cycle", cyc, x.cyc);
                chk("result", int'(result), int'(x.res));
                chk("zero", int'(zero), int'(x.z));
                chk("carry", int'(carry), int'(x.c));
                chk("overflow", int'(overflow), int'(x.v));
                chk("err", int'(err), int'(x.e));
            end
        end
        prev_valid = valid;
    end

    // One-cycle strobe: 0=ld_a, 1=ld_b, 2=ld_op
    task automatic pulse(input int which, input logic [7:0] d);
        @(negedge clk);
        sw = d;
        if (which == 0) ld_a = 1'b1;
        else if (which == 1) ld_b = 1'b1;
        else ld_op = 1'b1;
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0; ld_op = 1'b0;
    endtask

    task automatic issue_op(input logic [5:0] op, input logic [7:0] r,
                            input bit z, input bit c, input bit v, input bit e);
        exp_t x;
        @(negedge clk);
        sw = {2'b10, op};
        ld_op = 1'b1;
        x.res = r; x.z = z & FL; x.c = c & FL; x.v = v & FL; x.e = e;
        x.cyc = cyc + 2;
        q.push_back(x);
        @(negedge clk);
        ld_op = 1'b0;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input logic [7:0] r, input bit z, input bit c, input bit v, input bit e);
        pulse(0, a);
        pulse(1, b);
        issue_op(op, r, z, c, v, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with ld_a held high through it: no edge must be seen afterwards
        ld_a = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        chk("rst_result", int'(result), 0);
        chk("rst_zero", int'(zero), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_valid", int'(valid), 0);
        chk("held_strobe_no_edge_busy", int'(busy), 0);
        ld_a = 1'b0;
        idle(1);

        // Arithmetic
        do_op(8'h7F, 8'h01, OP_ADD, 8'h80, 0, 0, 1, 0);
        do_op(8'h05, 8'h05, OP_SUB, 8'h00, 1, 0, 0, 0);
        do_op(8'h03, 8'h05, OP_SUB, 8'hFE, 0, 1, 0, 0);
        do_op(8'hFF, 8'h01, OP_ADD, 8'h00, 1, 1, 0, 0);
        do_op(8'h80, 8'h01, OP_SUB, 8'h7F, 0, 0, 1, 0);
        // Logic
        do_op(8'hCC, 8'hAA, OP_AND, 8'h88, 0, 0, 0, 0);
        do_op(8'hCC, 8'hAA, OP_OR,  8'hEE, 0, 0, 0, 0);
        do_op(8'hCC, 8'hAA, OP_XOR, 8'h66, 0, 0, 0, 0);
        do_op(8'hCC, 8'hAA, OP_NOR, 8'h11, 0, 0, 0, 0);
        // Shifts, including amounts at and beyond WIDTH
        do_op(8'h80, 8'h03, OP_SRA, 8'hF0, 0, 0, 0, 0);
        do_op(8'h80, 8'h09, OP_SRA, 8'hFF, 0, 0, 0, 0);
        do_op(8'h80, 8'h09, OP_SRL, 8'h00, 1, 0, 0, 0);
        do_op(8'h80, 8'h03, OP_SRL, 8'h10, 0, 0, 0, 0);
        do_op(8'h80, 8'h07, OP_SRL, 8'h01, 0, 0, 0, 0);
        do_op(8'h80, 8'h08, OP_SRL, 8'h00, 1, 0, 0, 0);
        do_op(8'h40, 8'h08, OP_SRA, 8'h00, 1, 0, 0, 0);

        // Out-of-order strobes, then A and B together: only A is taken
        pulse(1, 8'h11);
        pulse(2, {2'b00, OP_ADD});
        chk("ooo_still_idle_busy", int'(busy), 0);
        @(negedge clk);
        sw = 8'h5A; ld_a = 1'b1; ld_b = 1'b1;
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0;
        chk("ooo_wait_b_busy", int'(busy), 1);
        idle(3);
        chk("ooo_wait_b_busy_hold", int'(busy), 1);
        pulse(1, 8'h0F);
        issue_op(OP_AND, 8'h0A, 0, 0, 0, 0);

        // Undefined opcode
        do_op(8'h12, 8'h34, 6'h3F, 8'h00, 0, 0, 0, 1);
        idle(2);
        chk("err_hold", int'(err), 1);

        // Reset in WAIT_OP: outputs cleared, no valid
        pulse(0, 8'h21);
        pulse(1, 8'h43);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_waitop_err", int'(err), 0);
        chk("rst_waitop_valid", int'(valid), 0);
        chk("rst_waitop_busy", int'(busy), 0);
        pulse(2, {2'b00, OP_ADD});
        idle(3);
        chk("rst_waitop_op_ignored_busy", int'(busy), 0);

        // Nonzero result, then reset during EXEC aborts the next one
        do_op(8'h0F, 8'hF0, OP_OR, 8'hFF, 0, 0, 0, 0);
        pulse(0, 8'h01);
        pulse(1, 8'h01);
        @(negedge clk);
        sw = {2'b00, OP_ADD}; ld_op = 1'b1;
        @(negedge clk);
        ld_op = 1'b0;
        chk("exec_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_exec_valid", int'(valid), 0);
        chk("rst_exec_result", int'(result), 0);
        chk("rst_exec_busy", int'(busy), 0);
        idle(3);

        // Back-to-back after abort still works
        do_op(8'h7F, 8'h7F, OP_ADD, 8'hFE, 0, 0, 1, 0);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
